store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write queue between the CPU data-memory write port and the data RAM. Each CPU store is accepted in one cycle into a small FIFO and drained in order to memory when it accepts, so a busy RAM or MMIO write port does not stall execution until the queue is full. Loads issued on the CPU's second read port are checked against pending stores and return the youngest matching buffered data, so the CPU always sees its own writes.

## Interface
- DEPTH, 4, number of entries; power of two, 2..16
- AW, 16, address width
- DW, 16, data width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- wr_en  in  1  CPU store request (CPU `mem_write_en`)
- wr_addr  in  AW  store address
- wr_data  in  DW  store data
- wr_ready  out  1  entry available; a store with wr_en=1 and wr_ready=0 is not taken, and the CPU must hold it
- ld_addr  in  AW  CPU load address (CPU `mem_read1_addr`)
- ld_mem_data  in  DW  RAM read data for ld_addr
- ld_data  out  DW  data returned to CPU (CPU `mem_read1_data`)
- ld_hit  out  1  ld_data came from the buffer
- mem_wr_valid  out  1  head entry present
- mem_wr_addr  out  AW  head address
- mem_wr_data  out  DW  head data
- mem_wr_ready  in  1  RAM accepts head this cycle
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count==0

## Operation
- Storage: DEPTH entries of {addr, data}, plus a head pointer, a tail pointer and count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push: on wr_en && wr_ready, write the entry at tail, then tail+1 and count+1.
- Pop: on mem_wr_valid && mem_wr_ready, advance head (head+1) and count-1.
- Simultaneous push and pop: both happen in the same cycle and count is unchanged.
- Full (count==DEPTH):
  - wr_ready=0 in that cycle, even if a pop is occurring.
  - Space freed by the pop is usable from the next cycle.
- Empty: mem_wr_valid=0, and mem_wr_addr/mem_wr_data hold the value of the last-popped entry (don't-care).
- Ordering: strict FIFO; memory sees stores in CPU program order.
- Forwarding (combinational):
  - All valid entries are compared with ld_addr.
  - On a match, ld_data is the data of the youngest matching entry (closest to tail) and ld_hit=1.
  - Otherwise ld_data=ld_mem_data and ld_hit=0.
  - The entry being popped this cycle still forwards.
  - The store being pushed this cycle is NOT forwarded; it becomes visible the next cycle.
- Reset (asynchronous, any time, including mid-drain):
  - head, tail and count are cleared and every pending store is discarded.
  - Outputs go to wr_ready=1, mem_wr_valid=0, count=0, empty=1, ld_hit=0.
  - Entry payloads are not reset.

## Timing
- Store latency: a store pushed in cycle N is presented on mem_wr_valid/addr/data no earlier than cycle N+1.
- Throughput: one push and one pop per cycle.
- Registered vs combinational outputs:
  - mem_wr_valid, mem_wr_addr, mem_wr_data, wr_ready, count and empty depend only on registered state, with no combinational path from wr_en or mem_wr_ready.
  - ld_data/ld_hit are combinational from ld_addr, ld_mem_data and the stored entries.
- Handshake: mem_wr_addr/mem_wr_data are stable while mem_wr_valid=1 and mem_wr_ready=0.
- After rst_n deasserts, the first push is accepted on the first rising edge.

## Configuration
- STORE_BUFFER_COALESCE_EN defined:
  - Applies when a push matches the address of the youngest entry (tail-1), count≥2, and that entry is not the head being popped this cycle.
  - The data overwrites that entry in place; tail and count do not change.
  - While full, such a coalescing store is still accepted: wr_ready = !full || coalesce_possible, where coalesce_possible depends only on wr_addr vs the registered tail-1 entry.
- Undefined: every accepted store takes a new entry, and wr_ready = !full.

## Test plan
- Push 0x0010←0xAAAA with mem_wr_ready=0 → next cycle mem_wr_valid=1, addr 0x0010, data 0xAAAA, count=1. Then raise mem_wr_ready → one pop; next cycle empty=1.
- With mem_wr_ready=0, push 4 stores 0x20..0x23 → count=4 and wr_ready=0. A 5th wr_en is not taken. Release mem_wr_ready → drain order 0x20,0x21,0x22,0x23.
- Push 0x0030←0x1111, then 0x0030←0x2222, with ld_addr=0x0030 and ld_mem_data=0xDEAD → ld_data=0x2222, ld_hit=1. At ld_addr=0x0031 → 0xDEAD, ld_hit=0.
- Full buffer with mem_wr_ready=1 and wr_en=1 in the same cycle → pop occurs, push refused, count=3. The next cycle's push succeeds and count=4. Pointer wrap across ≥3 full cycles keeps FIFO order.
- Assert rst_n=0 mid-drain with count=3 → immediately mem_wr_valid=0, count=0, wr_ready=1. After release, a push of 0x0040←0x5555 is the first store presented.
- With STORE_BUFFER_COALESCE_EN, mem_wr_ready=0, push 0x50,0x51,0x51←0x7777 → count=2 and drain yields 0x50 then 0x51/0x7777. Without the macro → count=3.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: posted-write queue between the CPU store port and the data RAM.
// CPU stores are accepted in one cycle into a DEPTH-entry FIFO and drained in
// program order whenever memory accepts the head entry. Loads on the CPU's
// second read port are checked against pending stores; the youngest matching
// buffered store is forwarded so the CPU always observes its own writes.
//
// Optional feature macro: STORE_BUFFER_COALESCE_EN
//   When defined, a store to the same address as the youngest entry (count>=2)
//   overwrites that entry in place instead of taking a new slot, and is
//   accepted even when the buffer is full.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   wr_en/wr_addr/wr_data/wr_ready  CPU store request / accept
//   ld_addr, ld_mem_data            CPU load address and RAM read data
//   ld_data, ld_hit                 forwarded load data, forwarded-from-buffer flag
//   mem_wr_valid/addr/data/ready    head entry handshake toward RAM
//   count, empty                    occupancy status
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DW-1:0]              wr_data,
    output logic                       wr_ready,
    input  logic [AW-1:0]              ld_addr,
    input  logic [DW-1:0]              ld_mem_data,
    output logic [DW-1:0]              ld_data,
    output logic                       ld_hit,
    output logic                       mem_wr_valid,
    output logic [AW-1:0]              mem_wr_addr,
    output logic [DW-1:0]              mem_wr_data,
    input  logic                       mem_wr_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] cnt;

    logic          full;
    logic          push, pop, alloc, coalesce;
    logic [PW-1:0] youngest, last_popped;

    assign full        = (cnt == CW'(DEPTH));
    assign youngest    = tail - PW'(1);
    assign last_popped = head - PW'(1);

`ifdef STORE_BUFFER_COALESCE_EN
    // With count>=2 the youngest entry can never be the head, so a coalesce
    // never races with that entry being popped.
    logic coalesce_possible;
    assign coalesce_possible = (cnt >= CW'(2)) && (addr_q[youngest] == wr_addr);
    assign wr_ready = !full || coalesce_possible;
    assign coalesce = push && coalesce_possible;
`else
    assign wr_ready = !full;
    assign coalesce = 1'b0;
`endif

    assign push  = wr_en && wr_ready;
    assign pop   = mem_wr_valid && mem_wr_ready;
    assign alloc = push && !coalesce;

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (alloc) tail <= tail + PW'(1);
            if (pop)   head <= head + PW'(1);
            case ({alloc, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail] <= wr_addr;
            data_q[tail] <= wr_data;
        end else if (coalesce) begin
            data_q[youngest] <= wr_data;
        end
    end

    assign count        = cnt;
    assign empty        = (cnt == '0);
    assign mem_wr_valid = !empty;
    // When empty the head slot is stale; show the last-popped entry instead.
    assign mem_wr_addr  = empty ? addr_q[last_popped] : addr_q[head];
    assign mem_wr_data  = empty ? data_q[last_popped] : data_q[head];

    // Forwarding: scan oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] idx;
        ld_data = ld_mem_data;
        ld_hit  = 1'b0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < cnt) && (addr_q[idx] == ld_addr)) begin
                ld_data = data_q[idx];
                ld_hit  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, AW=DW=16).
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_addr, wr_data;
    logic        wr_ready;
    logic [15:0] ld_addr, ld_mem_data, ld_data;
    logic        ld_hit;
    logic        mem_wr_valid;
    logic [15:0] mem_wr_addr, mem_wr_data;
    logic        mem_wr_ready;
    logic [2:0]  count;
    logic        empty;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .ld_addr(ld_addr), .ld_mem_data(ld_mem_data), .ld_data(ld_data), .ld_hit(ld_hit),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ready(mem_wr_ready), .count(count), .empty(empty)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are settled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    logic [15:0] q[$];
    logic [15:0] nxt;
    bit          do_push, do_pop;

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        ld_addr = 16'h0010; ld_mem_data = 16'hDEAD; mem_wr_ready = 1'b0;
        #12;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_valid", mem_wr_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ld_hit", ld_hit, 0);
        rst_n = 1'b1;
        step();

        // Single store then single pop
        push(16'h0010, 16'hAAAA);
        chk("t1_valid", mem_wr_valid, 1);
        chk("t1_addr", mem_wr_addr, 16'h0010);
        chk("t1_data", mem_wr_data, 16'hAAAA);
        chk("t1_count", count, 1);
        mem_wr_ready = 1'b1;
        step();
        mem_wr_ready = 1'b0;
        chk("t1_empty", empty, 1);
        chk("t1_valid0", mem_wr_valid, 0);

        // Fill, refuse 5th, drain in order
        for (int i = 0; i < 4; i++) push(16'h0020 + 16'(i), 16'h1000 + 16'(i));
        chk("t2_count", count, 4);
        chk("t2_wr_ready", wr_ready, 0);
        push(16'h0024, 16'h1004);
        chk("t2_count_hold", count, 4);
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_addr", mem_wr_addr, 16'h0020 + 16'(i));
            chk("t2_drain_data", mem_wr_data, 16'h1000 + 16'(i));
            step();
        end
        mem_wr_ready = 1'b0;
        chk("t2_empty", empty, 1);

        // Forwarding
        push(16'h0030, 16'h1111);
        push(16'h0030, 16'h2222);
        chk("t3_count", count, 2);
        ld_addr = 16'h0030; #1;
        chk("t3_fwd_data", ld_data, 16'h2222);
        chk("t3_fwd_hit", ld_hit, 1);
        ld_addr = 16'h0031; #1;
        chk("t3_miss_data", ld_data, 16'hDEAD);
        chk("t3_miss_hit", ld_hit, 0);
        ld_addr = 16'h0032; wr_en = 1'b1; wr_addr = 16'h0032; wr_data = 16'h3333; #1;
        chk("t3_push_not_fwd", ld_hit, 0);
        step();
        wr_en = 1'b0; #1;
        chk("t3_push_next_fwd", ld_data, 16'h3333);
        ld_addr = 16'h0030; mem_wr_ready = 1'b1; ld_mem_data = 16'hBEEF; #1;
        chk("t3_popping_fwd", ld_data, 16'h2222);
        step(); step(); step();
        mem_wr_ready = 1'b0; #1;
        chk("t3_empty", empty, 1);
        chk("t3_no_hit", ld_hit, 0);

        // Full with simultaneous pop: push refused
        for (int i = 0; i < 4; i++) push(16'h0060 + 16'(i), 16'h6000 + 16'(i));
        mem_wr_ready = 1'b1; wr_en = 1'b1; wr_addr = 16'h0064; wr_data = 16'h6004; #1;
        chk("t4_full_ready", wr_ready, 0);
        step();
        mem_wr_ready = 1'b0;
        chk("t4_count3", count, 3);
        chk("t4_ready_again", wr_ready, 1);
        step();
        wr_en = 1'b0;
        chk("t4_count4", count, 4);
        q = {16'h0061, 16'h0062, 16'h0063, 16'h0064};
        // Streaming with pointer wrap; expected queue kept by the bench.
        nxt = 16'h0070;
        for (int k = 0; k < 24; k++) begin
            wr_en = 1'b1; wr_addr = nxt; wr_data = nxt ^ 16'hA5A5;
            mem_wr_ready = (k % 3) != 0;
            #1;
            chk("t4_wr_ready", wr_ready, q.size() < 4);
            if (q.size() > 0) chk("t4_order", mem_wr_addr, q[0]);
            do_push = q.size() < 4;
            do_pop  = mem_wr_ready && q.size() > 0;
            step();
            if (do_pop) void'(q.pop_front());
            if (do_push) begin q.push_back(nxt); nxt++; end
        end
        wr_en = 1'b0;
        chk("t4_stream_count", count, q.size());
        mem_wr_ready = 1'b1;
        for (int k = 0; k < 8 && q.size() > 0; k++) begin
            chk("t4_tail_order", mem_wr_addr, q[0]);
            void'(q.pop_front());
            step();
        end
        mem_wr_ready = 1'b0;
        chk("t4_drained", empty, 1);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 4; i++) push(16'h0080 + 16'(i), 16'h8000 + 16'(i));
        mem_wr_ready = 1'b1;
        step();
        chk("t5_count3", count, 3);
        ld_addr = 16'h0083;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", mem_wr_valid, 0);
        chk("t5_count", count, 0);
        chk("t5_wr_ready", wr_ready, 1);
        chk("t5_empty", empty, 1);
        chk("t5_ld_hit", ld_hit, 0);
        mem_wr_ready = 1'b0;
        #3 rst_n = 1'b1;
        step();
        push(16'h0040, 16'h5555);
        chk("t5_first_addr", mem_wr_addr, 16'h0040);
        chk("t5_first_data", mem_wr_data, 16'h5555);
        chk("t5_first_count", count, 1);
        mem_wr_ready = 1'b1;
        step();
        mem_wr_ready = 1'b0;

        // Same-address back-to-back stores
        push(16'h0050, 16'h0500);
        push(16'h0051, 16'h0510);
        push(16'h0051, 16'h7777);
        mem_wr_ready = 1'b1; #1;
`ifdef STORE_BUFFER_COALESCE_EN
        chk("t6_count", count, 2);
        chk("t6_d0_addr", mem_wr_addr, 16'h0050);
        step();
        chk("t6_d1_addr", mem_wr_addr, 16'h0051);
        chk("t6_d1_data", mem_wr_data, 16'h7777);
        step();
`else
        chk("t6_count", count, 3);
        chk("t6_d0_addr", mem_wr_addr, 16'h0050);
        step();
        chk("t6_d1_addr", mem_wr_addr, 16'h0051);
        chk("t6_d1_data", mem_wr_data, 16'h0510);
        step();
        chk("t6_d2_addr", mem_wr_addr, 16'h0051);
        chk("t6_d2_data", mem_wr_data, 16'h7777);
        step();
`endif
        chk("t6_empty", empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
